// File: rtl/multi_delay_timer_pkg.sv
// multi_delay_timer_pkg: channel state type, reset period and channel index width helpers
package multi_delay_timer_pkg;
  typedef enum logic {IDLE, RUN} ch_state_t;
  function automatic int ch_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int reset_period_cycles(input int period_ns, input int cycle_ns);
    return period_ns / cycle_ns;
  endfunction
endpackage

// File: rtl/delay_timer_channel.sv
// delay_timer_channel: one timer channel with edge arm, cancel, reload and done pulse (status when MULTI_DELAY_TIMER_STATUS_EN)
module delay_timer_channel
  import multi_delay_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cancel,
  input  logic                 periodic,
  input  logic                 ld_hit,
  input  logic [CNT_WIDTH-1:0] ld_val,
  input  logic [CNT_WIDTH-1:0] period,
`ifdef MULTI_DELAY_TIMER_STATUS_EN
  input  logic                 status_clr,
  output logic                 status,
`endif
  output logic                 busy,
  output logic                 done
);
  logic                 start_q;
  logic                 rise;
  logic                 expire;
  logic                 done_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] eff;
  ch_state_t            st;
  always_comb begin
    st     = cnt != '0 ? RUN : IDLE;
    rise   = start & ~start_q;
    eff    = ld_hit ? ld_val : period;
    expire = st == RUN && cnt == CNT_WIDTH'(1);
    done_d = !cancel && !rise && expire;
    cnt_d  = cancel ? '0 :
             rise   ? eff :
             expire ? (periodic && period != '0 ? period : '0) :
             st == RUN ? cnt - CNT_WIDTH'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      cnt     <= cnt_d;
      done    <= done_d;
    end
  end
  assign busy = st == RUN;
`ifdef MULTI_DELAY_TIMER_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= 1'b0;
    else        status <= (status & ~status_clr) | done;
  end
`endif
endmodule

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: NUM_CH programmable delay timers with shared period load port (status when MULTI_DELAY_TIMER_STATUS_EN)
module multi_delay_timer
  import multi_delay_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int DEFAULT_PERIOD = 0,
  parameter int CYCLE_TIME     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             cancel,
  input  logic [NUM_CH-1:0]             periodic,
  input  logic                          period_ld,
  input  logic [ch_idx_w(NUM_CH)-1:0]   period_ch,
  input  logic [CNT_WIDTH-1:0]          period_val,
`ifdef MULTI_DELAY_TIMER_STATUS_EN
  input  logic [NUM_CH-1:0]             status_clr,
  output logic [NUM_CH-1:0]             status,
`endif
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             done
);
  localparam int                   CH_IDX_W = ch_idx_w(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] RST_P    = CNT_WIDTH'(reset_period_cycles(DEFAULT_PERIOD, CYCLE_TIME));
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                 ld_hit;
    logic [CNT_WIDTH-1:0] per_q;
    assign ld_hit = period_ld && period_ch == CH_IDX_W'(c);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      per_q <= RST_P;
      else if (ld_hit) per_q <= period_val;
    end
    delay_timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[c]),
      .cancel     (cancel[c]),
      .periodic   (periodic[c]),
      .ld_hit     (ld_hit),
      .ld_val     (period_val),
      .period     (per_q),
`ifdef MULTI_DELAY_TIMER_STATUS_EN
      .status_clr (status_clr[c]),
      .status     (status[c]),
`endif
      .busy       (busy[c]),
      .done       (done[c])
    );
  end
endmodule
